// File: rtl/dcache_wt.sv
// dcache_wt: write-through, no-write-allocate, direct-mapped data cache.
//
// Sits between the core data port (dreq/dresp) and the shared memory bus
// (creq/cresp). Requests with addr[31]==1 are cacheable. Load misses refill a
// whole 32-byte line with a 4-beat incrementing burst. Stores always go to the
// bus as a single beat, and they also update the line when it hits.
// Requests with addr[31]==0 are MMIO and go to the bus as one uncached beat.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   dreq_valid/addr/size/strobe/data   core request, held until data_ok
//   dresp_addr_ok/data_ok/data         core response, one-cycle pulse
//   creq_valid/is_write/size/addr/strobe/data/len   bus request
//   cresp_ready/last/data              bus beat handshake and read data
module dcache_wt #(
    parameter int SETS  = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [2:0]  creq_size,
    output logic [63:0] creq_addr,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    output logic [3:0]  creq_len,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int WSEL_W = $clog2(WORDS);
    localparam int TAG_W  = 27 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_WRITE,
        S_UNCACHED,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [63:0]       r_addr;
    logic [2:0]        r_size;
    logic [7:0]        r_strobe;
    logic [63:0]       r_wdata;
    logic [WSEL_W-1:0] r_cnt;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [63:0]       r_line [SETS][WORDS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WSEL_W-1:0] w_wsel;
    logic              w_store;
    logic              w_hit;
    logic [63:0]       w_word;
    logic [63:0]       w_merged;
    logic              w_last_beat;

    assign w_idx       = r_addr[5 +: IDX_W];
    assign w_tag       = r_addr[31 -: TAG_W];
    assign w_wsel      = r_addr[3 +: WSEL_W];
    assign w_store     = (r_strobe != 8'h00);
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word      = r_line[w_idx][w_wsel];
    assign w_last_beat = cresp_ready && cresp_last;

    // Store-hit byte merge into the resident word.
    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < 8; b++) begin
            if (r_strobe[b]) begin
                w_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_n     = r_state;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 64'h0;
        creq_valid    = 1'b0;
        creq_is_write = 1'b0;
        creq_size     = r_size;
        creq_addr     = r_addr;
        creq_strobe   = r_strobe;
        creq_data     = r_wdata;
        creq_len      = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (dreq_valid) begin
                    w_state_n = dreq_addr[31] ? S_LOOKUP : S_UNCACHED;
                end
            end
            S_LOOKUP: begin
                if (w_store) begin
                    w_state_n = S_WRITE;
                end else if (w_hit) begin
                    dresp_addr_ok = 1'b1;
                    dresp_data_ok = 1'b1;
                    dresp_data    = w_word;
                    w_state_n     = S_IDLE;
                end else begin
                    w_state_n = S_REFILL;
                end
            end
            S_REFILL: begin
                creq_valid  = 1'b1;
                creq_size   = 3'd3;
                creq_addr   = {r_addr[63:5], 5'b0};
                creq_strobe = 8'h00;
                creq_data   = 64'h0;
                creq_len    = 4'd3;
                if (w_last_beat) begin
                    w_state_n = S_RESP;
                end
            end
            S_RESP: begin
                dresp_addr_ok = 1'b1;
                dresp_data_ok = 1'b1;
                dresp_data    = w_word;
                w_state_n     = S_IDLE;
            end
            S_WRITE: begin
                creq_valid    = 1'b1;
                creq_is_write = 1'b1;
                if (w_last_beat) begin
                    dresp_addr_ok = 1'b1;
                    dresp_data_ok = 1'b1;
                    w_state_n     = S_IDLE;
                end
            end
            S_UNCACHED: begin
                creq_valid    = 1'b1;
                creq_is_write = w_store;
                if (w_last_beat) begin
                    dresp_addr_ok = 1'b1;
                    dresp_data_ok = 1'b1;
                    dresp_data    = w_store ? 64'h0 : cresp_data;
                    w_state_n     = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
        // Outputs are quiet while reset is held, whatever state was in flight.
        if (reset) begin
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            dresp_data    = 64'h0;
            creq_valid    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            // Invalidate on refill entry so an aborted refill leaves no valid line.
            if (r_state == S_LOOKUP && !w_store && !w_hit) begin
                r_valid[w_idx] <= 1'b0;
                r_cnt          <= '0;
            end
            if (r_state == S_REFILL && cresp_ready) begin
                r_cnt <= r_cnt + 1'b1;
                if (cresp_last) begin
                    r_valid[w_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && dreq_valid) begin
            r_addr   <= dreq_addr;
            r_size   <= dreq_size;
            r_strobe <= dreq_strobe;
            r_wdata  <= dreq_data;
        end
        if (r_state == S_LOOKUP && w_store && w_hit) begin
            r_line[w_idx][w_wsel] <= w_merged;
        end
        if (r_state == S_REFILL && cresp_ready) begin
            r_line[w_idx][r_cnt] <= cresp_data;
            if (cresp_last) begin
                r_tag[w_idx] <= w_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed bench for dcache_wt. A task acts as both core and bus
// responder: it issues one core request, answers every bus beat with ready=1,
// and records the bus transaction and the core response.
module tb_dcache_wt;

    logic        clk;
    logic        reset;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid;
    logic        creq_is_write;
    logic [2:0]  creq_size;
    logic [63:0] creq_addr;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic [3:0]  creq_len;
    logic        cresp_ready;
    logic        cresp_last;
    logic [63:0] cresp_data;

    int checks = 0;
    int errors = 0;

    // Results of the most recent do_req call.
    int          r_nreq;
    int          r_cyc;
    logic [63:0] r_rdata;
    logic        r_aok;
    logic [63:0] r_baddr;
    logic [3:0]  r_blen;
    logic        r_bwr;
    logic [7:0]  r_bstrb;
    logic [63:0] r_bdata;
    logic [2:0]  r_bsize;
    logic        r_unstable;

    dcache_wt #(.SETS(16), .WORDS(4)) dut (
        .clk(clk), .reset(reset),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write),
        .creq_size(creq_size), .creq_addr(creq_addr), .creq_strobe(creq_strobe),
        .creq_data(creq_data), .creq_len(creq_len),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: each 64-bit word holds a marker and its own address.
    function automatic logic [63:0] beat_data(input logic [63:0] a);
        return {32'hC0DE_0000, a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [63:0] a, input logic [2:0] sz,
                          input logic [7:0] st, input logic [63:0] d);
        int  beat;
        int  cyc;
        bit  done;
        bit  prev_cv;
        beat = 0; cyc = 0; done = 0; prev_cv = 0;
        r_nreq = 0; r_cyc = -1; r_rdata = '0; r_aok = 0; r_unstable = 0;
        r_baddr = '0; r_blen = '0; r_bwr = 0; r_bstrb = '0; r_bdata = '0; r_bsize = '0;
        @(negedge clk);
        dreq_valid = 1'b1; dreq_addr = a; dreq_size = sz; dreq_strobe = st; dreq_data = d;
        while (!done && cyc < 60) begin
            if (creq_valid) begin
                if (!prev_cv) begin
                    r_nreq++;
                    r_baddr = creq_addr; r_blen = creq_len; r_bwr = creq_is_write;
                    r_bstrb = creq_strobe; r_bdata = creq_data; r_bsize = creq_size;
                    beat = 0;
                end else if (creq_addr !== r_baddr || creq_len !== r_blen ||
                             creq_is_write !== r_bwr || creq_size !== r_bsize) begin
                    r_unstable = 1'b1;
                end
                cresp_ready = 1'b1;
                cresp_last  = (beat == int'(creq_len));
                cresp_data  = creq_is_write ? 64'h0 : beat_data(creq_addr + 64'(8 * beat));
            end else begin
                cresp_ready = 1'b0;
                cresp_last  = 1'b0;
                cresp_data  = 64'h0;
            end
            #1;
            if (dresp_data_ok) begin
                done = 1; r_cyc = cyc; r_rdata = dresp_data; r_aok = dresp_addr_ok;
                dreq_valid = 1'b0;
            end
            if (cresp_ready) beat++;
            prev_cv = creq_valid;
            @(negedge clk);
            cyc++;
        end
        cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'h0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL req_timeout: observed no data_ok for addr %h expected data_ok within 60 cycles", a);
        end
    endtask

    initial begin
        reset = 1'b1;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_0010; dreq_size = 3'd3;
        dreq_strobe = 8'h00; dreq_data = 64'h0;
        cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr_ok", {63'h0, dresp_addr_ok}, 64'h0);
        chk("rst_data_ok", {63'h0, dresp_data_ok}, 64'h0);
        chk("rst_data",    dresp_data, 64'h0);
        chk("rst_creq_valid", {63'h0, creq_valid}, 64'h0);
        dreq_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Cold load: line refill, response 6 cycles after valid.
        do_req(64'h8000_0010, 3'd3, 8'h00, 64'h0);
        chk("cold_nreq",  64'(r_nreq), 64'd1);
        chk("cold_baddr", r_baddr, 64'h8000_0000);
        chk("cold_len",   {60'h0, r_blen}, 64'd3);
        chk("cold_wr",    {63'h0, r_bwr}, 64'd0);
        chk("cold_size",  {61'h0, r_bsize}, 64'd3);
        chk("cold_stable", {63'h0, r_unstable}, 64'd0);
        chk("cold_cyc",   64'(r_cyc), 64'd6);
        chk("cold_data",  r_rdata, 64'hC0DE_0000_8000_0010);
        chk("cold_aok",   {63'h0, r_aok}, 64'd1);

        // Reload hits in one cycle without touching the bus.
        do_req(64'h8000_0010, 3'd3, 8'h00, 64'h0);
        chk("hit_nreq", 64'(r_nreq), 64'd0);
        chk("hit_cyc",  64'(r_cyc), 64'd1);
        chk("hit_data", r_rdata, 64'hC0DE_0000_8000_0010);
        do_req(64'h8000_0018, 3'd3, 8'h00, 64'h0);
        chk("hit_w3_data", r_rdata, 64'hC0DE_0000_8000_0018);

        // Store hit: one bus write, line updated with merged bytes.
        do_req(64'h8000_0008, 3'd2, 8'h0F, 64'h0000_0000_1111_2222);
        chk("st_nreq",  64'(r_nreq), 64'd1);
        chk("st_wr",    {63'h0, r_bwr}, 64'd1);
        chk("st_len",   {60'h0, r_blen}, 64'd0);
        chk("st_strb",  {56'h0, r_bstrb}, 64'h0F);
        chk("st_addr",  r_baddr, 64'h8000_0008);
        chk("st_wdata", r_bdata, 64'h0000_0000_1111_2222);
        chk("st_size",  {61'h0, r_bsize}, 64'd2);
        chk("st_cyc",   64'(r_cyc), 64'd2);
        do_req(64'h8000_0008, 3'd3, 8'h00, 64'h0);
        chk("merge_nreq", 64'(r_nreq), 64'd0);
        chk("merge_data", r_rdata, 64'hC0DE_0000_1111_2222);

        // Store miss: bus write only, no allocation.
        do_req(64'h8000_1000, 3'd3, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
        chk("stm_nreq", 64'(r_nreq), 64'd1);
        chk("stm_wr",   {63'h0, r_bwr}, 64'd1);
        chk("stm_len",  {60'h0, r_blen}, 64'd0);
        do_req(64'h8000_1000, 3'd3, 8'h00, 64'h0);
        chk("stm_ld_nreq", 64'(r_nreq), 64'd1);
        chk("stm_ld_len",  {60'h0, r_blen}, 64'd3);
        chk("stm_ld_data", r_rdata, 64'hC0DE_0000_8000_1000);

        // MMIO load: single beat each time, never cached.
        do_req(64'h4000_0008, 3'd3, 8'h00, 64'h0);
        chk("mmio_nreq", 64'(r_nreq), 64'd1);
        chk("mmio_len",  {60'h0, r_blen}, 64'd0);
        chk("mmio_addr", r_baddr, 64'h4000_0008);
        chk("mmio_data", r_rdata, 64'hC0DE_0000_4000_0008);
        chk("mmio_cyc",  64'(r_cyc), 64'd1);
        do_req(64'h4000_0008, 3'd3, 8'h00, 64'h0);
        chk("mmio2_nreq", 64'(r_nreq), 64'd1);
        // MMIO store returns zero data.
        do_req(64'h4000_0010, 3'd2, 8'hF0, 64'h1234_5678_0000_0000);
        chk("mmio_st_wr",   {63'h0, r_bwr}, 64'd1);
        chk("mmio_st_data", r_rdata, 64'h0);

        // Index conflict: 0x8000_0000 and 0x8000_0200 share set 0.
        do_req(64'h8000_0000, 3'd3, 8'h00, 64'h0);
        chk("cf_a_nreq", 64'(r_nreq), 64'd1);
        chk("cf_a_data", r_rdata, 64'hC0DE_0000_8000_0000);
        do_req(64'h8000_0200, 3'd3, 8'h00, 64'h0);
        chk("cf_b_nreq", 64'(r_nreq), 64'd1);
        chk("cf_b_addr", r_baddr, 64'h8000_0200);
        chk("cf_b_data", r_rdata, 64'hC0DE_0000_8000_0200);
        do_req(64'h8000_0000, 3'd3, 8'h00, 64'h0);
        chk("cf_a2_nreq", 64'(r_nreq), 64'd1);

        // Reset in the middle of a refill of line 0x8000_0060 after two beats.
        @(negedge clk);
        dreq_valid = 1'b1; dreq_addr = 64'h8000_0068; dreq_size = 3'd3;
        dreq_strobe = 8'h00; dreq_data = 64'h0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cresp_ready = 1'b1; cresp_last = 1'b0;
            cresp_data  = beat_data(creq_addr + 64'(8 * k));
            #1;
            chk("rr_creq_valid", {63'h0, creq_valid}, 64'd1);
            chk("rr_creq_addr",  creq_addr, 64'h8000_0060);
        end
        @(negedge clk);
        cresp_ready = 1'b0; cresp_data = 64'h0; dreq_valid = 1'b0; reset = 1'b1;
        #1;
        chk("rr_in_reset_cv", {63'h0, creq_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rr_after_cv", {63'h0, creq_valid}, 64'd0);
        chk("rr_after_dok", {63'h0, dresp_data_ok}, 64'd0);
        do_req(64'h8000_0068, 3'd3, 8'h00, 64'h0);
        chk("rr_ld_nreq", 64'(r_nreq), 64'd1);
        chk("rr_ld_len",  {60'h0, r_blen}, 64'd3);
        chk("rr_ld_cyc",  64'(r_cyc), 64'd6);
        chk("rr_ld_data", r_rdata, 64'hC0DE_0000_8000_0068);
        // Reset also dropped the previously valid line in set 0.
        do_req(64'h8000_0000, 3'd3, 8'h00, 64'h0);
        chk("rr_inv_nreq", 64'(r_nreq), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Write-through, no-write-allocate, direct-mapped data cache between the core's dbus port and the shared cbus memory interface.
- Consumes every core load/store request.
- Cacheable requests (addr[31]==1) are served from on-chip line storage or refilled with a 4-beat burst.
- MMIO requests (addr[31]==0) bypass the cache as single-beat bus transactions.

Parameters:
- SETS, 16, number of lines; power of two ≥2; index = addr[5 +: log2(SETS)].
- WORDS, 4, 64-bit words per line (line = 32 B); offset = addr[4:0], word select = addr[4:3].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dreq_valid  in  1  core request valid; held stable until data_ok
- dreq_addr  in  64  byte address
- dreq_size  in  3  log2 bytes (0..3)
- dreq_strobe  in  8  byte write enables; 0 = load
- dreq_data  in  64  store data, lane-aligned
- dresp_addr_ok  out  1  request accepted (pulses together with data_ok)
- dresp_data_ok  out  1  request complete, one-cycle pulse
- dresp_data  out  64  load data, lane-aligned, valid with data_ok
- creq_valid  out  1  bus request valid
- creq_is_write  out  1  bus write
- creq_size  out  3  beat size
- creq_addr  out  64  bus address
- creq_strobe  out  8  write strobes
- creq_data  out  64  write data
- creq_len  out  4  beats-1 (0 single, 3 burst)
- cresp_ready  in  1  beat handshake
- cresp_last  in  1  final beat
- cresp_data  in  64  read beat data

Behaviour:
- Reset: all valid bits 0, state IDLE.
  - Outputs during reset: dresp_addr_ok=0, dresp_data_ok=0, dresp_data=0, creq_valid=0.
  - Reset wins over any in-flight operation; the partial refill is discarded and its line stays invalid.
- Storage: per set one valid bit, tag = addr[31:5+log2(SETS)], WORDS×64b data, all flops.
- States: IDLE, LOOKUP, REFILL, WRITE, UNCACHED, RESP.
- IDLE:
  - dreq_valid=1 latches addr/size/strobe/data.
  - Goes UNCACHED if addr[31]==0, else LOOKUP.
- LOOKUP: hit = valid[idx] && tag match.
  - Load hit: addr_ok=data_ok=1 this cycle, dresp_data = selected word; → IDLE. Latency: valid seen in cycle N, data_ok in N+1.
  - Load miss: → REFILL.
  - Store (strobe≠0): on hit, merge the strobed bytes into the line this cycle. Hit or miss, → WRITE. Lines are never allocated on a store miss.
- REFILL:
  - Request: creq_valid=1, is_write=0, size=3, len=3, addr = line-aligned (addr[4:0]=0), burst incrementing from word 0.
  - Each cresp_ready beat writes word k (k = 0..3 counter).
  - On the cresp_ready&&cresp_last beat: set valid and tag; → RESP.
  - valid[idx] is cleared on REFILL entry, so a reset mid-refill never leaves a partial line valid.
- RESP: addr_ok=data_ok=1, data = refilled word at addr[4:3]; → IDLE.
- WRITE:
  - Request: creq_valid=1, is_write=1, len=0, with latched size, addr, strobe, data.
  - On cresp_ready&&cresp_last: addr_ok=data_ok=1 in that same cycle; → IDLE.
- UNCACHED:
  - Request: single beat with latched fields; is_write = (strobe≠0).
  - On cresp_ready&&cresp_last: data_ok, dresp_data = cresp_data (0 for stores); → IDLE. The cache array is never touched.
- creq_* fields are constant while creq_valid=1. creq_valid drops in the cycle after the last beat.
- After data_ok the cache is in IDLE on the next cycle. A request still asserted then is treated as new; the core drops or changes dreq_valid in the same edge it samples data_ok.
- Store to the same line as a later load: the line is updated in LOOKUP, so the following load hits with merged data. No write buffer; store completion waits for the bus.
- Index aliasing: a refill overwrites the resident line unconditionally. No dirty state exists (write-through).
- dreq_size is passed through unchanged; misaligned accesses are trapped upstream and never reach this block.

Test Plan:
- Load 0x8000_0010 cold → REFILL with creq_addr=0x8000_0000, len=3; beats D0..D3 → data_ok with data=D2, 6 cycles after valid given 1-cycle ready per beat. Reload of the same address → data_ok one cycle after valid, no creq_valid.
- Store strobe=0x0F, data=0x1111_2222 to cached 0x8000_0008 → one bus write (len=0, strobe 0x0F). Load of 0x8000_0008 then hits and returns the upper bytes of old D1 merged with 0x1111_2222 in the lower 4 bytes.
- Store to uncached-line 0x8000_1000 (miss) → single bus write only. Subsequent load of it → refill, proving no allocation.
- MMIO load 0x4000_0008 → single-beat read, len=0. Returned cresp_data appears on dresp_data. Repeat load → second bus read (never cached).
- Conflict: load 0x8000_0000 then 0x8000_0200 (same index for SETS=16) → second refills. Reload of 0x8000_0000 misses again.
- Assert reset after beat 2 of a refill → creq_valid=0 next cycle. A later load of that line triggers a full refill and returns correct data.
